// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary converter: counts the ones in a window of 2^WIDTH-1
// valid bitstream samples and presents the count with a valid/ready handshake.
module stoch_to_bin #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             sbit,
    input  logic             sbit_valid,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Sample index of the final sample in a window (WINDOW - 1).
    localparam logic [WIDTH-1:0] LAST_SAMPLE = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] ones_q,   ones_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q,  valid_d;
    logic             busy_q,   busy_d;
    logic [WIDTH-1:0] sbit_ext_s;

    assign sbit_ext_s = {{(WIDTH-1){1'b0}}, sbit};

    // Next-state and next-output logic for the conversion FSM.
    always_comb begin
        state_d  = state_q;
        ones_d   = ones_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    ones_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                // abort outranks both a valid sample and window completion
                if (abort) begin
                    state_d = S_IDLE;
                    ones_d  = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (sbit_valid) begin
                    cnt_d  = cnt_q + ONE;
                    ones_d = ones_q + sbit_ext_s;
                    if (cnt_q == LAST_SAMPLE) begin
                        state_d  = S_DONE;
                        result_d = ones_q + sbit_ext_s;
                        valid_d  = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d = S_ACCUM;
                        ones_d  = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ones_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign busy         = busy_q;

endmodule
